uart_tx_arbiter: RTL

- Shares one UART_Tx instance among NUM_REQ byte producers using round-robin arbitration.
- Each cycle: latch one requester's byte, pulse the transmitter's start input, wait for the transmitter's done edge, then return per-requester completion.
- Adds a configurable inter-frame guard gap and a watchdog timeout so a stuck transmitter cannot hang the requesters.
- Sits between the producer logic and UART_Tx; its tx_* ports wire directly to UART_Tx clk/start_sending/data_in/busy/done.

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings, default bit
// period and a constant clog2 used to size ports and counters.
package uart_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GUARD = 2'd3;

    localparam int DEFAULT_CLKS_PER_BIT = 100;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin selector: first asserted request at or after ptr, wrapping
// modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     grant,
    output logic               any_valid
);

    always_comb begin
        int idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                grant     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers with round-robin
// grants, an optional inter-frame guard gap and a watchdog on the done edge.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int GUARD_CLKS   = 0,
    parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT,
    localparam int IDW         = clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     req_done,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [IDW-1:0]         grant_id,
    output logic                   active,
    output logic                   timeout_err,
    output logic [1:0]             state_dbg
);

    localparam int WD_W = clog2(TIMEOUT_CLKS + 1);
    localparam int GW   = clog2(GUARD_CLKS + 2);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0]   GUARD_LAST = GW'((GUARD_CLKS > 0) ? GUARD_CLKS - 1 : 0);

    logic [1:0]      state;
    logic [IDW-1:0]  ptr;
    logic            tx_done_q;
    logic [WD_W-1:0] wd_cnt;
    logic [GW-1:0]   guard_cnt;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;
    logic            done_edge;
    logic            wd_expired;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (pick_id),
        .any_valid (pick_any)
    );

    assign done_edge  = tx_done & ~tx_done_q;
    assign wd_expired = (wd_cnt == WD_LAST);
    assign state_dbg  = state;

    // Handshake: a requester holds req_valid and its byte until it sees its
    // req_ack pulse; the byte is captured on that cycle and req_done follows
    // once the transmitter signals completion (never after a watchdog abort).
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            tx_done_q   <= 1'b0;
            wd_cnt      <= '0;
            guard_cnt   <= '0;
            req_ack     <= '0;
            req_done    <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_done_q   <= tx_done;
            req_ack     <= '0;
            req_done    <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // tx_busy gating also covers a frame still draining after reset.
                    if (!tx_busy && pick_any) begin
                        req_ack  <= NUM_REQ'(1) << pick_id;
                        tx_data  <= req_data[8*pick_id +: 8];
                        grant_id <= pick_id;
                        active   <= 1'b1;
                        ptr      <= (pick_id == IDW'(NUM_REQ - 1)) ? '0 : pick_id + IDW'(1);
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    tx_start <= 1'b1;
                    wd_cnt   <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_edge) begin
                        req_done <= NUM_REQ'(1) << grant_id;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                    end
                    if (done_edge || wd_expired) begin
                        if (GUARD_CLKS > 0) begin
                            guard_cnt <= '0;
                            state     <= ST_GUARD;
                        end else begin
                            active <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end
                default: begin
                    active <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
